// File: rtl/tag_array_ctrl.sv
// -----------------------------------------------------------------------------
// tag_array_ctrl
//
// Client-side controller for a 4-way, SETS-deep banked tag SRAM whose entries
// are {valid, tag}. After reset it clears every set of the array, then serves
// single-outstanding tag lookups (hit, one-hot hit way, one-hot victim way) and
// one-hot-masked refill writes. The array sits next to this block and has a
// one-cycle read latency.
//
// Optional build macro:
//   TAG_ARRAY_CTRL_PLRU_EN - replace the global round-robin replacement pointer
//                            with a per-set 3-bit tree-PLRU register file.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   req_valid/req_ready          lookup request handshake
//   req_set, req_tag             lookup set index and tag
//   resp_valid/resp_ready        lookup result handshake
//   resp_hit, resp_way_oh        hit flag and one-hot hit way (0 on miss)
//   resp_victim_oh               one-hot victim way (meaningful on a miss)
//   fill_valid/fill_ready        refill handshake
//   fill_set, fill_tag           refill set index and tag
//   fill_way_oh                  one-hot way mask to write
//   init_done                    array clear finished
//   sram_r_addr                  array read address
//   sram_r_data_0..3             array read data per way (one cycle later)
//   sram_w_en, sram_w_addr       array write enable and address
//   sram_w_data_0..3             array write data per way
//   sram_w_maskOH                array per-way write mask
// -----------------------------------------------------------------------------
module tag_array_ctrl #(
    parameter int SETS  = 512,
    parameter int WAYS  = 4,
    parameter int TAG_W = 18,
    localparam int AW   = $clog2(SETS),
    localparam int EW   = TAG_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_set,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [WAYS-1:0]  resp_way_oh,
    output logic [WAYS-1:0]  resp_victim_oh,
    input  logic             fill_valid,
    output logic             fill_ready,
    input  logic [AW-1:0]    fill_set,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [WAYS-1:0]  fill_way_oh,
    output logic             init_done,
    output logic [AW-1:0]    sram_r_addr,
    input  logic [EW-1:0]    sram_r_data_0,
    input  logic [EW-1:0]    sram_r_data_1,
    input  logic [EW-1:0]    sram_r_data_2,
    input  logic [EW-1:0]    sram_r_data_3,
    output logic             sram_w_en,
    output logic [AW-1:0]    sram_w_addr,
    output logic [EW-1:0]    sram_w_data_0,
    output logic [EW-1:0]    sram_w_data_1,
    output logic [EW-1:0]    sram_w_data_2,
    output logic [EW-1:0]    sram_w_data_3,
    output logic [WAYS-1:0]  sram_w_maskOH
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_hit_q, resp_hit_d;
    logic [WAYS-1:0]  resp_way_q, resp_way_d;
    logic [WAYS-1:0]  resp_victim_q, resp_victim_d;

    logic             req_ready_s;
    logic             fill_ready_s;
    logic             fill_fire_s;
    logic             req_fire_s;
    logic             w_en_s;
    logic [AW-1:0]    w_addr_s;
    logic [EW-1:0]    w_data_s;
    logic [WAYS-1:0]  w_mask_s;
    logic [AW-1:0]    r_addr_s;

    logic [EW-1:0]    rd_s [WAYS];
    logic [WAYS-1:0]  hit_vec_s;
    logic [WAYS-1:0]  inv_vec_s;
    logic [WAYS-1:0]  repl_oh_s;
    logic [WAYS-1:0]  victim_s;

    // Isolate the lowest set bit: used both for multi-hit priority and for
    // the invalid-first victim choice.
    function automatic logic [3:0] lowest_oh(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    assign rd_s[0] = sram_r_data_0;
    assign rd_s[1] = sram_r_data_1;
    assign rd_s[2] = sram_r_data_2;
    assign rd_s[3] = sram_r_data_3;

    // Per-way tag compare and invalid-way decode on the returned read data
    always_comb begin
        hit_vec_s = '0;
        inv_vec_s = '0;
        for (int k = 0; k < WAYS; k++) begin
            hit_vec_s[k] = rd_s[k][TAG_W] && (rd_s[k][TAG_W-1:0] == tag_q);
            inv_vec_s[k] = !rd_s[k][TAG_W];
        end
    end

    // Victim: an empty way always wins over the replacement policy
    always_comb begin
        victim_s = repl_oh_s;
        if (|inv_vec_s) begin
            victim_s = lowest_oh(inv_vec_s);
        end else begin
            victim_s = repl_oh_s;
        end
    end

`ifdef TAG_ARRAY_CTRL_PLRU_EN
    // Tree bits: [0] root (0 -> ways 0/1 are LRU side), [1] pair 0/1
    // (1 -> way 1 is LRU), [2] pair 2/3 (1 -> way 3 is LRU).
    logic [2:0]    plru_q [SETS];
    logic [AW-1:0] set_q, set_d;
    logic          plru_we_s;
    logic [AW-1:0] plru_idx_s;
    logic [2:0]    plru_wdata_s;
    logic [2:0]    plru_cur_s;

    // Point the tree away from the way just touched
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [3:0] oh);
        logic [2:0] n;
        n = p;
        case (oh)
            4'b0001: begin n[0] = 1'b1; n[1] = 1'b1; end
            4'b0010: begin n[0] = 1'b1; n[1] = 1'b0; end
            4'b0100: begin n[0] = 1'b0; n[2] = 1'b1; end
            4'b1000: begin n[0] = 1'b0; n[2] = 1'b0; end
            default: n = p;
        endcase
        return n;
    endfunction

    // Follow the tree bits to the least recently used way
    function automatic logic [3:0] plru_victim(input logic [2:0] p);
        logic [3:0] v;
        if (!p[0]) begin
            v = p[1] ? 4'b0010 : 4'b0001;
        end else begin
            v = p[2] ? 4'b1000 : 4'b0100;
        end
        return v;
    endfunction

    assign plru_cur_s = plru_q[set_q];
    assign repl_oh_s  = plru_victim(plru_cur_s);

    // Remember the looked-up set so LOOKUP can address its PLRU entry
    always_comb begin
        set_d = set_q;
        if (req_fire_s) begin
            set_d = req_set;
        end else begin
            set_d = set_q;
        end
    end

    // PLRU update source: fills (IDLE) and hits (LOOKUP) never coincide
    always_comb begin
        plru_we_s    = 1'b0;
        plru_idx_s   = set_q;
        plru_wdata_s = plru_cur_s;
        if (fill_fire_s) begin
            plru_we_s    = 1'b1;
            plru_idx_s   = fill_set;
            plru_wdata_s = plru_touch(plru_q[fill_set], lowest_oh(fill_way_oh));
        end else if ((state_q == ST_LOOKUP) && (|hit_vec_s)) begin
            plru_we_s    = 1'b1;
            plru_idx_s   = set_q;
            plru_wdata_s = plru_touch(plru_cur_s, lowest_oh(hit_vec_s));
        end else begin
            plru_we_s    = 1'b0;
        end
    end

    // PLRU register file and latched lookup set
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SETS; i++) begin
                plru_q[i] <= 3'b000;
            end
            set_q <= '0;
        end else begin
            if (plru_we_s) begin
                plru_q[plru_idx_s] <= plru_wdata_s;
            end
            set_q <= set_d;
        end
    end
`else
    logic [1:0] rr_q, rr_d;

    assign rr_d      = fill_fire_s ? (rr_q + 2'd1) : rr_q;
    assign repl_oh_s = {{(WAYS-1){1'b0}}, 1'b1} << rr_q;

    // Global round-robin pointer, advanced by every accepted fill
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Next-state logic and same-cycle array / handshake controls
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_done_d   = init_done_q;
        tag_d         = tag_q;
        resp_valid_d  = resp_valid_q;
        resp_hit_d    = resp_hit_q;
        resp_way_d    = resp_way_q;
        resp_victim_d = resp_victim_q;
        req_ready_s   = 1'b0;
        fill_ready_s  = 1'b0;
        fill_fire_s   = 1'b0;
        req_fire_s    = 1'b0;
        w_en_s        = 1'b0;
        w_addr_s      = '0;
        w_data_s      = '0;
        w_mask_s      = '0;
        r_addr_s      = '0;
        // While reset is held every control output stays at its idle value
        if (reset) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    w_en_s   = 1'b1;
                    w_addr_s = cnt_q;
                    w_mask_s = {WAYS{1'b1}};
                    if (cnt_q == AW'(SETS - 1)) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    fill_ready_s = 1'b1;
                    req_ready_s  = !fill_valid;
                    // A fill wins the cycle; it never reads, so no collision
                    if (fill_valid) begin
                        fill_fire_s = 1'b1;
                        w_en_s      = 1'b1;
                        w_addr_s    = fill_set;
                        w_mask_s    = fill_way_oh;
                        w_data_s    = {1'b1, fill_tag};
                    end else if (req_valid) begin
                        req_fire_s = 1'b1;
                        r_addr_s   = req_set;
                        tag_d      = req_tag;
                        state_d    = ST_LOOKUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    resp_valid_d  = 1'b1;
                    resp_hit_d    = |hit_vec_s;
                    resp_way_d    = lowest_oh(hit_vec_s);
                    resp_victim_d = victim_s;
                    state_d       = ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            init_done_q   <= 1'b0;
            tag_q         <= '0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_victim_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_done_q   <= init_done_d;
            tag_q         <= tag_d;
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            resp_way_q    <= resp_way_d;
            resp_victim_q <= resp_victim_d;
        end
    end

    assign req_ready      = req_ready_s;
    assign fill_ready     = fill_ready_s;
    assign init_done      = init_done_q;
    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_way_oh    = resp_way_q;
    assign resp_victim_oh = resp_victim_q;
    assign sram_r_addr    = r_addr_s;
    assign sram_w_en      = w_en_s;
    assign sram_w_addr    = w_addr_s;
    assign sram_w_maskOH  = w_mask_s;
    assign sram_w_data_0  = w_data_s;
    assign sram_w_data_1  = w_data_s;
    assign sram_w_data_2  = w_data_s;
    assign sram_w_data_3  = w_data_s;

endmodule

// File: doc/tag_array_ctrl.md
Name: tag_array_ctrl

Overview:
- Client-side controller for the 4-way, 512-set, 19-bit two-port banked tag SRAM array.
- Clears the array after reset, then serves tag lookups: hit or miss, hit way, and a victim way on a miss.
- Performs refill writes using a one-hot way mask.
- Sits between the cache pipeline and the tag array; the array is instantiated next to it.

Parameters:
- SETS, 512, number of sets; address width is log2(SETS) = 9.
- WAYS, 4, number of ways; fixed at 4.
- TAG_W, 18, tag width; entry = {valid, tag} = TAG_W+1 = 19 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  controller can accept a lookup
- req_set  in  9  lookup set index
- req_tag  in  18  lookup tag
- resp_valid  out  1  lookup result valid
- resp_ready  in  1  consumer accepts result
- resp_hit  out  1  tag matched a valid way
- resp_way_oh  out  4  one-hot hit way; 0 on miss
- resp_victim_oh  out  4  one-hot victim way; meaningful on miss
- fill_valid  in  1  refill request valid
- fill_ready  out  1  controller accepts refill
- fill_set  in  9  refill set index
- fill_tag  in  18  refill tag
- fill_way_oh  in  4  one-hot way to write
- init_done  out  1  array clear complete
- sram_r_addr  out  9  array read address
- sram_r_data_0..3  in  19 each  array read data per way
- sram_w_en  out  1  array write enable
- sram_w_addr  out  9  array write address
- sram_w_data_0..3  out  19 each  array write data per way
- sram_w_maskOH  out  4  array per-way write mask

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous and active-high. All state, including mid-INIT progress, is cleared on any cycle with reset=1.
- Reset values:
  - init_done=0, req_ready=0, fill_ready=0, resp_valid=0, resp_hit=0.
  - resp_way_oh=0, resp_victim_oh=0.
  - sram_w_en=0, sram_w_addr=0, sram_w_maskOH=0, sram_r_addr=0.
  - Round-robin pointer=0; state=INIT with clear counter=0.
- Array timing: read data is valid exactly 1 cycle after sram_r_addr is presented. A write commits at the clock edge where sram_w_en=1.
- FSM states: INIT, IDLE, LOOKUP, RESP.
- INIT:
  - Each cycle: sram_w_en=1, sram_w_addr=counter, all sram_w_data=0, sram_w_maskOH=4'b1111.
  - Counter increments by 1 per cycle. After writing set 511, go to IDLE and set init_done=1 (stays 1 until reset).
  - INIT lasts exactly 512 cycles. req_ready=0 and fill_ready=0 throughout.
- IDLE:
  - fill_ready=1. A fill has priority over a lookup.
  - Fill accepted (fill_valid=1): same cycle, sram_w_en=1, sram_w_addr=fill_set, sram_w_maskOH=fill_way_oh, and every sram_w_data_i={1'b1, fill_tag}. State stays IDLE.
  - req_ready = !fill_valid. On req_valid&&req_ready: sram_r_addr=req_set, req_tag latched, go to LOOKUP.
- LOOKUP (1 cycle):
  - hit_i = sram_r_data_i[18] && sram_r_data_i[17:0]==tag.
  - resp_way_oh = hit vector. If more than one way hits, the lowest index is kept.
  - Victim = lowest-index invalid way if any; otherwise the one-hot of the round-robin pointer.
  - Results are registered; go to RESP.
- RESP:
  - resp_valid=1 and outputs held stable until resp_ready=1, then go to IDLE.
  - A new request is not accepted in the same cycle as resp_ready (single outstanding request).
- Round-robin pointer: 2-bit. Increments by 1 on every accepted fill; wraps 3->0.
- No reads are issued while a write is pending, so there is no read/write collision by construction.
- fill_way_oh is not checked. A value of 0 produces sram_w_en=1 with mask 0, i.e. no effective write.

Optional Feature:
- TAG_ARRAY_CTRL_PLRU_EN defined: the round-robin pointer is replaced by a per-set 3-bit tree-PLRU register file (SETS x 3 flops, cleared on reset).
  - PLRU bits are updated on a hit (at the LOOKUP cycle) and on a fill (using fill_way_oh).
  - When all ways are valid, the victim is the PLRU way.
- Undefined: global round-robin victim as described in Behaviour.
- The invalid-first victim rule applies in both cases.

Test Plan:
- Reset, then hold all inputs idle -> 512 consecutive writes with mask 4'b1111 and data 0 at addresses 0..511; init_done rises on cycle 513; req_ready rises with it.
- Lookup set 5, tag 0x00ABC after init -> resp_hit=0, resp_way_oh=0, resp_victim_oh=4'b0001; resp_valid exactly 2 cycles after the accept.
- Fill set 5, tag 0x00ABC, way 4'b0100, then lookup the same -> sram_w_data_2=0x40ABC with mask 4'b0100; lookup returns hit=1, way_oh=4'b0100.
- Fill all 4 ways of set 9 with distinct tags, then lookup a missing tag -> victim = pointer one-hot, 4'b0001 after 4 fills without the macro. With TAG_ARRAY_CTRL_PLRU_EN after fills in order 0,1,2,3 -> victim 4'b0001.
- fill_valid and req_valid asserted together in IDLE -> fill written that cycle, req_ready=0; request accepted the next cycle.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0; reset asserted mid-INIT at set 200 -> counter restarts at 0 and takes a full 512 cycles.
